// File: rtl/sd_pkg.sv
// Shared sigma-delta definitions: default widths, FSM states and window constants.
// Both the ADC front end and the DAC bitstream path take their width from here.
package sd_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Last count of a decimation window at the default width.
    localparam logic [DATA_W_DEF-1:0] WIN_END = DATA_W_DEF'((1 << DATA_W_DEF) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } sd_state_e;

endpackage

// File: rtl/sd_adc_if.sv
// Comparator-side and sample-side signals of the sigma-delta ADC.
// The bench or game logic holds the master end; sd_adc holds the slave end.
interface sd_adc_if
    import sd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              Enable;
    logic              CompIn;
    logic              FbOut;
    logic [DATA_W-1:0] ADCout;
    logic              ADCvalid;

    modport master (
        output Enable,
        output CompIn,
        input  FbOut,
        input  ADCout,
        input  ADCvalid
    );

    modport slave (
        input  Enable,
        input  CompIn,
        output FbOut,
        output ADCout,
        output ADCvalid
    );
endinterface

// File: rtl/sync_ff.sv
// Flop chain for bringing an asynchronous input into the clk domain.
// Cleared asynchronously so no stale level survives a reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sd_adc.sv
// First-order sigma-delta ADC: closes the comparator/RC loop through FbOut and
// boxcar-decimates the feedback bitstream into one sample per 2^DATA_W clocks.
module sd_adc
    import sd_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic     CLK,
    input  logic     Reset_n,
    sd_adc_if.slave  bus
);

    localparam int ACC_W = DATA_W + 1;

    logic              comp_s;
    sd_state_e         state_q;
    logic              fb_q;
    logic [DATA_W-1:0] win_cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0] adc_q;
    logic              valid_q;

    logic              win_end_d;
    logic [ACC_W-1:0]  total_d;
    logic [DATA_W-1:0] sample_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (CLK),
        .rst_n (Reset_n),
        .d_i   (bus.CompIn),
        .q_o   (comp_s)
    );

    // The feedback bit present at the window-end edge still belongs to the
    // closing window, so it is folded into the total here.
    always_comb begin
        win_end_d = (win_cnt_q == '1);
        total_d   = acc_q + ACC_W'(fb_q);
        sample_d  = total_d[DATA_W] ? '1 : total_d[DATA_W-1:0];
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            fb_q      <= 1'b0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            adc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.Enable) begin
                // Dropping Enable wins over a coinciding window end.
                state_q   <= IDLE;
                fb_q      <= 1'b0;
                win_cnt_q <= '0;
                acc_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SETTLE;
                        fb_q    <= 1'b0;
                    end
                    SETTLE, RUN: begin
                        fb_q <= comp_s;
                        if (win_end_d) begin
                            win_cnt_q <= '0;
                            acc_q     <= '0;
                            state_q   <= RUN;
                            // The settle window only lets the integrator converge.
                            if (state_q == RUN) begin
                                adc_q   <= sample_d;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            win_cnt_q <= win_cnt_q + DATA_W'(1);
                            acc_q     <= total_d;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        fb_q      <= 1'b0;
                        win_cnt_q <= '0;
                        acc_q     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.FbOut    = fb_q;
    assign bus.ADCout   = adc_q;
    assign bus.ADCvalid = valid_q;

endmodule
